// File: rtl/sopc_dbus_fabric.sv
// sopc_dbus_fabric
// Data-bus fabric between the OpenMIPS data port and NSLV memory-mapped slaves.
// Each access is decoded by its top SEL_W address bits and routed to one slave
// through a ce/ack handshake. The CPU is stalled until the access completes.
// Unmapped accesses and accesses the slave never answers become a one-cycle
// bus-error pulse, and the faulting address is captured.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   m_ce_i/m_we_i/m_addr_i        CPU request, direction and byte address
//   m_sel_i/m_data_i              CPU byte enables and write data
//   m_data_o/m_stall_o/m_err_o    read data, pipeline stall, bus-error pulse
//   err_addr_o                    address of the most recent faulting access
//   s_ce_o                        one-hot slave strobe, high during ACCESS
//   s_we_o/s_addr_o/s_sel_o/s_data_o  latched request towards the slaves
//   s_data_i/s_ack_i              packed slave read data and completion pulses
module sopc_dbus_fabric #(
    parameter int unsigned NSLV    = 4,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_ce_i,
    input  logic                m_we_i,
    input  logic [AW-1:0]       m_addr_i,
    input  logic [DW/8-1:0]     m_sel_i,
    input  logic [DW-1:0]       m_data_i,
    output logic [DW-1:0]       m_data_o,
    output logic                m_stall_o,
    output logic                m_err_o,
    output logic [AW-1:0]       err_addr_o,
    output logic [NSLV-1:0]     s_ce_o,
    output logic                s_we_o,
    output logic [AW-1:0]       s_addr_o,
    output logic [DW/8-1:0]     s_sel_o,
    output logic [DW-1:0]       s_data_o,
    input  logic [NSLV*DW-1:0]  s_data_i,
    input  logic [NSLV-1:0]     s_ack_i
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e              state_q;
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [DW/8-1:0]     sel_q;
    logic [DW-1:0]       wdata_q;
    logic [NSLV-1:0]     ce_q;
    logic [DW-1:0]       rdata_q;
    logic                err_q;
    logic [AW-1:0]       err_addr_q;
    logic [15:0]         cnt_q;

    logic [SEL_W-1:0]    m_idx;
    logic                m_mapped;
    logic [NSLV-1:0]     m_onehot;
    logic                ack_hit;
    logic [DW-1:0]       ack_data;

    always_comb begin
        m_idx    = m_addr_i[AW-1 -: SEL_W];
        m_mapped = 32'(m_idx) < NSLV;
        m_onehot = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            m_onehot[k] = (32'(m_idx) == k);
        end
    end

    // ce_q holds the one-hot decode of the latched index, so masking the acks
    // with it keeps only the selected slave and only while in ACCESS.
    always_comb begin
        ack_hit  = |(s_ack_i & ce_q);
        ack_data = '0;
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (ce_q[k]) begin
                ack_data = s_data_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            ce_q       <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (m_ce_i) begin
                        if (m_mapped) begin
                            we_q    <= m_we_i;
                            addr_q  <= m_addr_i;
                            sel_q   <= m_sel_i;
                            wdata_q <= m_data_i;
                            ce_q    <= m_onehot;
                            cnt_q   <= '0;
                            state_q <= StAccess;
                        end else begin
                            err_addr_q <= m_addr_i;
                            err_q      <= 1'b1;
                            rdata_q    <= '0;
                            state_q    <= StDone;
                        end
                    end
                end
                StAccess: begin
                    // An ack in the timeout cycle still completes the access.
                    if (ack_hit) begin
                        rdata_q <= we_q ? '0 : ack_data;
                        ce_q    <= '0;
                        state_q <= StDone;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                        rdata_q    <= '0;
                        ce_q       <= '0;
                        state_q    <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_stall_o  = m_ce_i & (state_q != StDone);
    assign m_data_o   = rdata_q;
    assign m_err_o    = err_q;
    assign err_addr_o = err_addr_q;
    assign s_ce_o     = ce_q;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_sel_o    = sel_q;
    assign s_data_o   = wdata_q;

endmodule

// File: tb/tb_sopc_dbus_fabric.sv
// Testbench for sopc_dbus_fabric: directed cases plus randomized accesses.
// A driver issues CPU requests and pushes the expected outcome into a queue;
// a slave responder acks after a planned number of wait cycles and injects
// stray acks; a monitor pops and compares whenever an access is presented.
module tb_sopc_dbus_fabric;

    localparam int NSLV    = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 99;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                m_ce_i = 1'b0;
    logic                m_we_i = 1'b0;
    logic [AW-1:0]       m_addr_i = '0;
    logic [DW/8-1:0]     m_sel_i = '0;
    logic [DW-1:0]       m_data_i = '0;
    logic [DW-1:0]       m_data_o;
    logic                m_stall_o;
    logic                m_err_o;
    logic [AW-1:0]       err_addr_o;
    logic [NSLV-1:0]     s_ce_o;
    logic                s_we_o;
    logic [AW-1:0]       s_addr_o;
    logic [DW/8-1:0]     s_sel_o;
    logic [DW-1:0]       s_data_o;
    logic [NSLV*DW-1:0]  s_data_i;
    logic [NSLV-1:0]     s_ack_i;

    sopc_dbus_fabric #(
        .NSLV    (NSLV),
        .AW      (AW),
        .DW      (DW),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m_ce_i     (m_ce_i),
        .m_we_i     (m_we_i),
        .m_addr_i   (m_addr_i),
        .m_sel_i    (m_sel_i),
        .m_data_i   (m_data_i),
        .m_data_o   (m_data_o),
        .m_stall_o  (m_stall_o),
        .m_err_o    (m_err_o),
        .err_addr_o (err_addr_o),
        .s_ce_o     (s_ce_o),
        .s_we_o     (s_we_o),
        .s_addr_o   (s_addr_o),
        .s_sel_o    (s_sel_o),
        .s_data_o   (s_data_o),
        .s_data_i   (s_data_i),
        .s_ack_i    (s_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          slave;
        logic        err;
        logic [31:0] data;
        logic [31:0] eaddr;
        int          stall;
        int          ce_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          cur_slave = 0;
    int          cur_wait = NEVER;
    logic [31:0] cur_data = '0;
    bit          stray_en = 1'b0;
    logic [31:0] last_eaddr = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Slave responder: acks the planned slave on its (wait+1)-th ACCESS cycle.
    initial begin : responder
        int cnt;
        logic [NSLV-1:0] ack;
        cnt = 0;
        s_ack_i = '0;
        s_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ack = '0;
            for (int k = 0; k < NSLV; k++) s_data_i[k*DW +: DW] = $urandom;
            if (s_ce_o != '0) cnt++;
            else cnt = 0;
            for (int k = 0; k < NSLV; k++) begin
                if (!s_ce_o[k] && stray_en && $urandom_range(0, 3) == 0) ack[k] = 1'b1;
            end
            if (cur_slave < NSLV && s_ce_o[cur_slave] && cnt == cur_wait + 1) begin
                ack[cur_slave] = 1'b1;
                s_data_i[cur_slave*DW +: DW] = cur_data;
            end
            s_ack_i = ack;
        end
    end

    // Monitor: checks the slave-side request during ACCESS and the CPU-side result in DONE.
    int              stall_cnt = 0;
    int              ce_cnt = 0;
    exp_t            me;
    logic [NSLV-1:0] oh;

    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0;
            ce_cnt = 0;
        end else begin
            if (m_ce_i && m_stall_o) stall_cnt++;
            if (s_ce_o != '0) begin
                ce_cnt++;
                if (exp_q.size() == 0) begin
                    chk("ce_without_request", s_ce_o, '0);
                end else begin
                    me = exp_q[0];
                    oh = '0;
                    if (me.slave < NSLV) oh[me.slave] = 1'b1;
                    chk("s_ce_onehot", s_ce_o, oh);
                    chk("s_we", s_we_o, me.we);
                    chk("s_addr", s_addr_o, me.addr);
                    chk("s_sel", s_sel_o, me.sel);
                    chk("s_data", s_data_o, me.wdata);
                end
            end
            if (m_ce_i && !m_stall_o) begin
                if (exp_q.size() == 0) begin
                    chk("done_without_request", 1'b1, 1'b0);
                end else begin
                    me = exp_q.pop_front();
                    chk("m_err", m_err_o, me.err);
                    chk("m_data", m_data_o, me.data);
                    chk("err_addr", err_addr_o, me.eaddr);
                    chk("stall_cycles", stall_cnt, me.stall);
                    chk("ce_cycles", ce_cnt, me.ce_cyc);
                end
                stall_cnt = 0;
                ce_cnt = 0;
            end else begin
                chk("err_outside_done", m_err_o, 1'b0);
            end
        end
    end

    function automatic exp_t model(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                                   input logic [31:0] wd, input int wt, input logic [31:0] rd);
        exp_t e;
        e.we = we;
        e.addr = addr;
        e.sel = sel;
        e.wdata = wd;
        e.slave = int'(addr[31:28]);
        if (e.slave >= NSLV) begin
            e.err = 1'b1;
            e.data = '0;
            e.eaddr = addr;
            e.stall = 1;
            e.ce_cyc = 0;
        end else if (wt < TIMEOUT) begin
            e.err = 1'b0;
            e.data = we ? 32'h0 : rd;
            e.eaddr = last_eaddr;
            e.stall = wt + 2;
            e.ce_cyc = wt + 1;
        end else begin
            e.err = 1'b1;
            e.data = '0;
            e.eaddr = addr;
            e.stall = TIMEOUT + 1;
            e.ce_cyc = TIMEOUT;
        end
        return e;
    endfunction

    // Issues one request in the next cycle and returns in its DONE cycle.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wd, input int wt, input logic [31:0] rd,
                          output int done_cyc);
        exp_t e;
        int budget;
        e = model(we, addr, sel, wd, wt, rd);
        if (e.err) last_eaddr = addr;
        cur_slave = e.slave;
        cur_wait = wt;
        cur_data = rd;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        m_ce_i = 1'b1;
        m_we_i = we;
        m_addr_i = addr;
        m_sel_i = sel;
        m_data_i = wd;
        budget = 0;
        do begin
            @(posedge clk);
            #1;
            budget++;
        end while (m_stall_o && budget < 100);
        if (m_stall_o) chk("access_completes", m_stall_o, 1'b0);
        done_cyc = cyc;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            m_ce_i = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int d0, d1, d2;
        int idx, wt;
        exp_t e;

        // Reset state
        #3;
        chk("rst_s_ce", s_ce_o, '0);
        chk("rst_s_we", s_we_o, 1'b0);
        chk("rst_s_addr", s_addr_o, '0);
        chk("rst_s_sel", s_sel_o, '0);
        chk("rst_s_data", s_data_o, '0);
        chk("rst_m_data", m_data_o, '0);
        chk("rst_m_err", m_err_o, 1'b0);
        chk("rst_err_addr", err_addr_o, '0);
        chk("rst_stall_idle", m_stall_o, 1'b0);
        m_ce_i = 1'b1;
        #1;
        chk("rst_stall_follows_ce", m_stall_o, 1'b1);
        m_ce_i = 1'b0;
        #8 rst = 1'b0;

        // Directed cases
        do_txn(1'b0, 32'h1000_0004, 4'hf, 32'h0, 0, 32'hDEAD_BEEF, d0);
        do_txn(1'b1, 32'h0000_0010, 4'b0011, 32'h1234_5678, 3, 32'hCAFE_F00D, d0);
        idle(1);
        do_txn(1'b0, 32'h7000_0000, 4'hf, 32'h0, NEVER, 32'h0, d0);
        idle(2);
        do_txn(1'b0, 32'h2000_0000, 4'hf, 32'h0, NEVER, 32'h0, d0);
        do_txn(1'b0, 32'h2000_0008, 4'hf, 32'h0, TIMEOUT - 1, 32'hA5A5_0008, d0);
        idle(1);
        stray_en = 1'b1;
        do_txn(1'b0, 32'h0000_0020, 4'hf, 32'h0, 2, 32'h0101_0202, d0);
        do_txn(1'b0, 32'h0000_0024, 4'hf, 32'h0, 0, 32'h1111_1111, d1);
        do_txn(1'b0, 32'h1000_0028, 4'hf, 32'h0, 0, 32'h2222_2222, d2);
        chk("back_to_back_spacing", d2 - d1, 3);
        idle(2);

        // Randomized accesses
        repeat (40) begin
            idx = $urandom_range(0, 5);
            wt = $urandom_range(0, 9);
            if (wt >= TIMEOUT) wt = NEVER;
            do_txn(1'($urandom_range(0, 1)), {4'(idx), 28'($urandom)}, 4'($urandom),
                   $urandom, wt, $urandom, d0);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        // Reset in the middle of an access
        stray_en = 1'b0;
        e = model(1'b0, 32'h2000_0040, 4'hf, 32'h0, NEVER, 32'h0);
        cur_slave = 2;
        cur_wait = NEVER;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        m_ce_i = 1'b1;
        m_we_i = 1'b0;
        m_addr_i = 32'h2000_0040;
        m_sel_i = 4'hf;
        m_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_s_ce", s_ce_o, '0);
        chk("mid_rst_err_addr", err_addr_o, '0);
        chk("mid_rst_m_err", m_err_o, 1'b0);
        chk("mid_rst_m_data", m_data_o, '0);
        exp_q.delete();
        last_eaddr = '0;
        m_ce_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;

        // Fabric must be usable again after the abandoned access
        do_txn(1'b0, 32'h3000_0000, 4'hf, 32'h0, 1, 32'h5A5A_3333, d0);
        idle(2);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
